// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Grant-state encoding and grant index width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int grant_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      idx,
  output logic               any
);

  int          j;
  logic [GW-1:0] jj;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = GW'(j);
      if (req[jj]) begin
        idx = jj;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among producers,
// with bounded bursts and full-flag back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_MAX  = 4,
  localparam int GW         = grant_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  localparam int            CW   = $clog2(BURST_MAX + 1);
  localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

  state_t        state;
  state_t        state_n;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] rr_ptr_n;
  logic [GW-1:0] grant_n;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] g_next;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] burst_n;
  logic [CW-1:0] cnt_inc;
  logic          pick_any;
  logic          g_valid;
  logic          xfer;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant_id  <= grant_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_n;
    end
  end

  assign g_valid = req_valid[grant_id];
  assign cnt_inc = burst_cnt + CW'(1);
  assign g_next  = (grant_id == LAST) ? '0 : grant_id + GW'(1);

  // rst_n gates the handshake so a reset cycle never writes.
  assign xfer = rst_n && (state == GRANT) && g_valid && !fifo_full;

  assign fifo_wr_en = xfer;
  assign busy       = (state == GRANT);

  always_comb begin
    req_ready    = '0;
    fifo_wr_data = '0;
    if (rst_n && state == GRANT)
      req_ready[grant_id] = ~fifo_full;
    if (xfer)
      fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant_id;
    rr_ptr_n = rr_ptr;
    burst_n  = burst_cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          grant_n = pick_idx;
          burst_n = '0;
        end
      end
      GRANT: begin
        if (!g_valid) begin
          state_n  = IDLE;
          rr_ptr_n = g_next;
        end else if (xfer) begin
          burst_n = cnt_inc;
          if (cnt_inc == CW'(BURST_MAX)) begin
            state_n  = IDLE;
            rr_ptr_n = g_next;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural arbiter model plus an
// 8-deep FIFO model, with directed scenarios and literal checks.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BM    = 4;
  localparam int DEPTH = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  // FIFO model: read side sees pre-edge occupancy, like the real FIFO.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rdq[$];
  logic          rd_en;
  int            fcount = 0;
  bit            ovf    = 0;

  assign fifo_full = (fcount == DEPTH);

  initial forever begin
    int occ;
    @(posedge clk);
    occ = fq.size();
    if (rd_en && occ > 0) rdq.push_back(fq.pop_front());
    if (fifo_wr_en) begin
      if (occ == DEPTH) ovf = 1;
      else fq.push_back(fifo_wr_data);
    end
    fcount <= fq.size();
  end

  // Observation logs of what the DUT did.
  int gcyc[$];
  int glog[$];
  int gwrites[$];
  int wlog[$];
  bit prev_busy = 0;

  task automatic clear_logs();
    gcyc.delete();
    glog.delete();
    gwrites.delete();
    wlog.delete();
    rdq.delete();
  endtask

  // Arbiter model: owner of the port (-1 = none), writes done,
  // and whose turn it is next.
  int m_owner = -1;
  int m_done  = 0;
  int m_ptr   = 0;
  int m_gid   = 0;

  initial forever begin
    logic [N-1:0]  e_ready;
    logic          e_wr;
    logic [DW-1:0] e_data;
    bit            found;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      m_owner   = -1;
      m_done    = 0;
      m_ptr     = 0;
      m_gid     = 0;
      prev_busy = 0;
    end else begin
      e_ready = '0;
      e_wr    = 1'b0;
      e_data  = '0;
      if (m_owner >= 0) begin
        if (!fifo_full) e_ready[m_owner] = 1'b1;
        e_wr = req_valid[m_owner] && !fifo_full;
        if (e_wr) e_data = req_data[m_owner*DW +: DW];
      end
      chk("ready", req_ready, e_ready);
      chk("wr_en", fifo_wr_en, e_wr);
      chk("wr_data", fifo_wr_data, e_data);
      chk("busy", busy, m_owner >= 0);
      chk("grant_id", grant_id, m_gid);
      chk("no_wr_when_full", fifo_wr_en && fifo_full, 0);

      if (busy && !prev_busy) begin
        glog.push_back(grant_id);
        gwrites.push_back(0);
        gcyc.push_back(cyc);
      end
      if (fifo_wr_en) begin
        wlog.push_back(cyc);
        if (gwrites.size() > 0)
          gwrites[gwrites.size()-1]++;
      end
      prev_busy = busy;

      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && req_valid[j]) begin
            found   = 1;
            m_owner = j;
            m_gid   = j;
            m_done  = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (e_wr) begin
        m_done++;
        if (m_done == BM) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  // Producer stimulus state.
  int            left[N];
  int            sent[N];
  int            pause_at[N];
  bit            paused[N];
  bit            inc[N];
  logic [DW-1:0] base[N];

  logic          s_wr;
  logic [N-1:0]  s_ready;
  logic          s_busy;
  logic [1:0]    s_gid;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (left[i] > 0) && !paused[i];
      req_data[i*DW +: DW] = base[i] + (inc[i] ? 8'(sent[i]) : 8'h00);
    end
  endtask

  task automatic set_prod(input int i, input int n, input logic [DW-1:0] b,
                          input bit incr, input int pa);
    left[i]     = n;
    sent[i]     = 0;
    base[i]     = b;
    inc[i]      = incr;
    pause_at[i] = pa;
    paused[i]   = 0;
    drive();
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc     = req_valid & req_ready;
    s_wr    = fifo_wr_en;
    s_ready = req_ready;
    s_busy  = busy;
    s_gid   = grant_id;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      paused[i] = 0;
      if (acc[i]) begin
        sent[i]++;
        left[i]--;
        if (sent[i] == pause_at[i]) paused[i] = 1;
      end
    end
    drive();
  endtask

  function automatic bit pending();
    pending = 0;
    for (int i = 0; i < N; i++)
      if (left[i] > 0) pending = 1;
  endfunction

  task automatic run_done(input string name, input int bound);
    int n;
    n = 0;
    while (pending() && n < bound) begin
      step();
      n++;
    end
    chk(name, n < bound, 1);
    repeat (3) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_en = 1'b1;
    while (fq.size() > 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain", fq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    int w0;
    int n;
    rst_n     = 1'b0;
    rd_en     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) set_prod(i, 0, 8'h00, 0, 0);

    // Reset, then one producer streaming 0x10..0x17.
    do_reset();
    step();
    chk("t1_rst_ready", s_ready, 0);
    chk("t1_rst_wr", s_wr, 0);
    chk("t1_rst_busy", s_busy, 0);
    chk("t1_rst_gid", s_gid, 0);
    clear_logs();
    t0 = cyc;
    set_prod(0, 8, 8'h10, 1, 0);
    run_done("t1_timeout", 40);
    drain();
    chk("t1_rd_count", rdq.size(), 8);
    for (int k = 0; k < 8 && k < rdq.size(); k++)
      chk("t1_rd_data", rdq[k], 8'h10 + k);
    chk("t1_grants", glog.size(), 2);
    chk("t1_busy_latency", gcyc.size() > 0 ? gcyc[0] - t0 : -1, 1);
    chk("t1_wr_latency", wlog.size() > 0 ? wlog[0] - t0 : -1, 1);
    if (wlog.size() >= 8) begin
      chk("t1_burst_run", wlog[3] - wlog[0], 3);
      chk("t1_bubble", wlog[4] - wlog[3], 2);
    end else begin
      chk("t1_wlog_size", wlog.size(), 8);
    end

    // All four producers: strict rotation, bursts of four.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_prod(i, 8, 8'hA0 + 8'(i), 0, 0);
    run_done("t2_timeout", 200);
    drain();
    chk("t2_grants", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) begin
      chk("t2_gid", glog[k], k % 4);
      chk("t2_burst", gwrites[k], 4);
    end
    chk("t2_rd_count", rdq.size(), 32);
    for (int k = 0; k < 32 && k < rdq.size(); k++)
      chk("t2_rd_data", rdq[k], 8'hA0 + 8'((k / 4) % 4));

    // Fill the FIFO, stall a grant on full, then release it.
    clear_logs();
    rd_en = 1'b0;
    set_prod(2, 12, 8'h30, 1, 0);
    n = 0;
    while (!(glog.size() == 3 && fifo_full) && n < 60) begin
      step();
      n++;
    end
    chk("t3_fill_timeout", n < 60, 1);
    w0 = wlog.size();
    repeat (5) step();
    chk("t3_stall_writes", wlog.size() - w0, 0);
    chk("t3_stall_burst", gwrites.size() == 3 ? gwrites[2] : -1, 0);
    chk("t3_stall_busy", s_busy, 1);
    chk("t3_stall_gid", s_gid, 2);
    rd_en = 1'b1;
    run_done("t3_timeout", 60);
    drain();
    chk("t3_grants", glog.size(), 3);
    chk("t3_last_burst", gwrites.size() == 3 ? gwrites[2] : -1, 4);
    chk("t3_overflow", ovf, 0);

    // Producer 1 pauses after two words: producer 2 goes next.
    clear_logs();
    set_prod(1, 4, 8'h60, 1, 2);
    set_prod(2, 4, 8'h70, 1, 0);
    run_done("t4_timeout", 60);
    chk("t4_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t4_g0", glog[0], 1);
      chk("t4_g1", glog[1], 2);
      chk("t4_g2", glog[2], 1);
      chk("t4_w0", gwrites[0], 2);
      chk("t4_w1", gwrites[1], 4);
      chk("t4_w2", gwrites[2], 2);
    end

    // Move the pointer to 3, then only producer 0: wrap to 0.
    clear_logs();
    set_prod(2, 1, 8'h80, 0, 0);
    run_done("t4b_timeout", 20);
    chk("t4b_gid", glog.size() > 0 ? glog[0] : -1, 2);
    clear_logs();
    set_prod(0, 2, 8'h90, 1, 0);
    run_done("t4c_timeout", 20);
    chk("t4c_wrap_gid", glog.size() > 0 ? glog[0] : -1, 0);

    // Reset lands on the second transfer of a burst.
    clear_logs();
    set_prod(3, 4, 8'h50, 1, 0);
    n = 0;
    while (!(gwrites.size() > 0 && gwrites[0] == 1) && n < 20) begin
      step();
      n++;
    end
    chk("t5_wait_timeout", n < 20, 1);
    rst_n = 1'b0;
    set_prod(0, 2, 8'hC0, 1, 0);
    step();
    chk("t5_rst_wr", s_wr, 0);
    chk("t5_rst_ready", s_ready, 0);
    chk("t5_no_accept", sent[3], 1);
    rst_n = 1'b1;
    clear_logs();
    step();
    chk("t5_post_busy", s_busy, 0);
    chk("t5_post_gid", s_gid, 0);
    chk("t5_post_ready", s_ready, 0);
    chk("t5_post_wr", s_wr, 0);
    run_done("t5_timeout", 40);
    chk("t5_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t5_g0", glog[0], 0);
      chk("t5_g1", glog[1], 3);
      chk("t5_w1", gwrites[1], 3);
    end
    chk("t5_overflow", ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
